// File: rtl/onchip_ram_arbiter_if.sv
// rtl/onchip_ram_arbiter_if.sv - Avalon-MM requester bus bundle shared by the RAM arbiter and its masters
interface onchip_ram_arbiter_if #(
    parameter int AW  = 13,
    parameter int DW  = 64,
    parameter int BEW = 8
);
    logic [AW-1:0]  address;
    logic           read;
    logic           write;
    logic [BEW-1:0] byteenable;
    logic [DW-1:0]  writedata;
    logic           waitrequest;
    logic [DW-1:0]  readdata;
    logic           readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_ram_arbiter.sv
// rtl/onchip_ram_arbiter.sv - two-master round-robin arbiter for the single-port on-chip RAM
// Define ONCHIP_RAM_ARB_FIXED_PRIO_EN to make m0 always win contention.
module onchip_ram_arbiter #(
    parameter int AW  = 13,
    parameter int DW  = 64,
    parameter int BEW = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    onchip_ram_arbiter_if.slave m0,
    onchip_ram_arbiter_if.slave m1,
    output logic [AW-1:0]    ram_address,
    output logic [BEW-1:0]   ram_byteenable,
    output logic             ram_chipselect,
    output logic             ram_write,
    output logic [DW-1:0]    ram_writedata,
    output logic             ram_clken,
    input  logic [DW-1:0]    ram_readdata
);

    logic req0;
    logic req1;
    logic gnt_vld;
    logic gnt_idx;
    logic sel_write;
    logic rd_accept;

    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;

    // Requests are masked during reset so the RAM sees no command.
    assign req0 = reset_n & (m0.read | m0.write);
    assign req1 = reset_n & (m1.read | m1.write);

`ifdef ONCHIP_RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = req0 | req1;
        gnt_idx = ~req0 & req1;
    end
`else
    logic last_grant_q, last_grant_d;

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_idx = 1'b0;
        if (req0 && req1) begin
            gnt_idx = ~last_grant_q;
        end else begin
            gnt_idx = req1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_vld) begin
            last_grant_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign sel_write = gnt_idx ? m1.write : m0.write;
    assign rd_accept = gnt_vld & ~sel_write;

    always_comb begin
        ram_chipselect = gnt_vld;
        ram_write      = gnt_vld & sel_write;
        ram_address    = gnt_idx ? m1.address : m0.address;
        ram_writedata  = gnt_idx ? m1.writedata : m0.writedata;
        ram_byteenable = '1;
        if (sel_write) begin
            ram_byteenable = gnt_idx ? m1.byteenable : m0.byteenable;
        end
    end

    assign ram_clken = 1'b1;

    assign m0.waitrequest = ~(gnt_vld & ~gnt_idx);
    assign m1.waitrequest = ~(gnt_vld & gnt_idx);

    always_comb begin
        rd_pend_d  = rd_accept;
        rd_owner_d = rd_owner_q;
        if (rd_accept) begin
            rd_owner_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // RAM read data is shared; readdatavalid steers it to the issuing master.
    assign m0.readdata      = ram_readdata;
    assign m1.readdata      = ram_readdata;
    assign m0.readdatavalid = reset_n & rd_pend_q & ~rd_owner_q;
    assign m1.readdatavalid = reset_n & rd_pend_q & rd_owner_q;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// tb/tb_onchip_ram_arbiter.sv - randomized self-checking bench for onchip_ram_arbiter
module tb_onchip_ram_arbiter;
    localparam int AW  = 13;
    localparam int DW  = 64;
    localparam int BEW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    onchip_ram_arbiter_if #(.AW(AW), .DW(DW), .BEW(BEW)) m0_if ();
    onchip_ram_arbiter_if #(.AW(AW), .DW(DW), .BEW(BEW)) m1_if ();

    logic [AW-1:0]  ram_address;
    logic [BEW-1:0] ram_byteenable;
    logic           ram_chipselect;
    logic           ram_write;
    logic [DW-1:0]  ram_writedata;
    logic           ram_clken;
    logic [DW-1:0]  ram_readdata = '0;

    onchip_ram_arbiter #(.AW(AW), .DW(DW), .BEW(BEW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_if),
        .m1             (m1_if),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
    );

    // Stand-in single-port RAM with one cycle read latency.
    logic [63:0] ram_mem [8192];
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 8; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
            end else begin
                ram_readdata <= ram_mem[ram_address];
            end
        end
    end

    // Stimulus state per master and the reference model.
    bit          m_rd [2];
    bit          m_wr [2];
    logic [12:0] m_addr [2];
    logic [7:0]  m_be [2];
    logic [63:0] m_wd [2];
    bit          acc [2];
    bit          rst_n;

    logic [63:0] ref_mem [8192];
    int          last_win;
    bit          exp_pend;
    int          exp_owner;
    logic [63:0] exp_data;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        bit          req0, req1, wr_g;
        int          win;
        @(negedge clk);
        reset_n           = rst_n;
        m0_if.read        = m_rd[0];
        m0_if.write       = m_wr[0];
        m0_if.address     = m_addr[0];
        m0_if.byteenable  = m_be[0];
        m0_if.writedata   = m_wd[0];
        m1_if.read        = m_rd[1];
        m1_if.write       = m_wr[1];
        m1_if.address     = m_addr[1];
        m1_if.byteenable  = m_be[1];
        m1_if.writedata   = m_wd[1];
        #1;
        req0 = m_rd[0] | m_wr[0];
        req1 = m_rd[1] | m_wr[1];
        win  = -1;
        if (rst_n) begin
            if (req0 && req1) begin
`ifdef ONCHIP_RAM_ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = (last_win == 0) ? 1 : 0;
`endif
            end else if (req0) win = 0;
            else if (req1) win = 1;
        end
        wr_g = (win >= 0) ? m_wr[win] : 1'b0;

        check("m0_waitrequest", 64'(m0_if.waitrequest), 64'(win != 0));
        check("m1_waitrequest", 64'(m1_if.waitrequest), 64'(win != 1));
        check("ram_chipselect", 64'(ram_chipselect), 64'(win >= 0));
        check("ram_write", 64'(ram_write), 64'(wr_g));
        check("ram_clken", 64'(ram_clken), 64'(1));
        if (win >= 0) begin
            check("ram_address", 64'(ram_address), 64'(m_addr[win]));
            check("ram_byteenable", 64'(ram_byteenable), 64'(wr_g ? m_be[win] : 8'hFF));
            if (wr_g) check("ram_writedata", ram_writedata, m_wd[win]);
        end
        check("m0_readdatavalid", 64'(m0_if.readdatavalid), 64'(rst_n && exp_pend && exp_owner == 0));
        check("m1_readdatavalid", 64'(m1_if.readdatavalid), 64'(rst_n && exp_pend && exp_owner == 1));
        if (rst_n && exp_pend)
            check("readdata", (exp_owner == 0) ? m0_if.readdata : m1_if.readdata, exp_data);

        if (!rst_n) begin
            exp_pend = 1'b0;
            last_win = 1;
        end else begin
            exp_pend = (win >= 0) && !wr_g;
            if (exp_pend) begin
                exp_owner = win;
                exp_data  = ref_mem[m_addr[win]];
            end
            if (win >= 0) last_win = win;
            if (wr_g)
                for (int b = 0; b < 8; b++)
                    if (m_be[win][b]) ref_mem[m_addr[win]][b*8 +: 8] = m_wd[win][b*8 +: 8];
        end
        acc[0] = (win == 0);
        acc[1] = (win == 1);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 1'b0;
            m_wr[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr, input logic [12:0] a,
                           input logic [7:0] be, input logic [63:0] wd);
        m_rd[i]   = rd;
        m_wr[i]   = wr;
        m_addr[i] = a;
        m_be[i]   = be;
        m_wd[i]   = wd;
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) begin
            ram_mem[a] = '0;
            ref_mem[a] = '0;
        end
        ram_mem[16'h0010] = 64'h1122334455667788;
        ref_mem[16'h0010] = 64'h1122334455667788;
        ram_mem[1] = 64'hA5A5A5A5_00000001;
        ref_mem[1] = 64'hA5A5A5A5_00000001;
        ram_mem[2] = 64'h5A5A5A5A_00000002;
        ref_mem[2] = 64'h5A5A5A5A_00000002;
        for (int i = 0; i < 2; i++) begin
            set_req(i, 1'b0, 1'b0, '0, '0, '0);
            acc[i] = 1'b0;
        end
        last_win  = 1;
        exp_pend  = 1'b0;
        exp_owner = 0;
        exp_data  = '0;

        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // Single m0 read of a preloaded word.
        set_req(0, 1'b1, 1'b0, 13'h0010, 8'h00, 64'h0);
        step();
        check("m0_first_read_accepted", 64'(acc[0]), 64'(1));
        idle_all();
        step();
        step();

        // Both masters reading continuously from reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 13'h0001, 8'h00, 64'h0);
        set_req(1, 1'b1, 1'b0, 13'h0002, 8'h00, 64'h0);
        repeat (6) step();
        idle_all();
        step();

        // Partial write at the top word, then read it back.
        set_req(1, 1'b0, 1'b1, 13'h1FFF, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
        step();
        set_req(1, 1'b1, 1'b0, 13'h1FFF, 8'h00, 64'h0);
        step();
        idle_all();
        step();
        check("ref_top_word", ref_mem[13'h1FFF], 64'h00000000FFFFFFFF);

        // Read and write together: the write wins.
        set_req(0, 1'b1, 1'b1, 13'h0004, 8'hFF, 64'hDEADBEEFCAFEF00D);
        step();
        idle_all();
        step();

        // Read accepted, then reset on the following edge.
        set_req(0, 1'b1, 1'b0, 13'h0010, 8'h00, 64'h0);
        step();
        idle_all();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Contention for four cycles, then m0 backs off.
        set_req(0, 1'b1, 1'b0, 13'h0001, 8'h00, 64'h0);
        set_req(1, 1'b1, 1'b0, 13'h0002, 8'h00, 64'h0);
        repeat (4) step();
        m_rd[0] = 1'b0;
        step();
        idle_all();
        step();

        // Randomized traffic with requests held until accepted.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                int kind;
                if (acc[i]) begin
                    m_rd[i] = 1'b0;
                    m_wr[i] = 1'b0;
                end
                if (!m_rd[i] && !m_wr[i] && $urandom_range(0, 9) < 6) begin
                    kind      = int'($urandom_range(0, 4));
                    m_rd[i]   = (kind <= 2) || (kind == 4);
                    m_wr[i]   = (kind == 3) || (kind == 4);
                    m_addr[i] = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 15))
                                                            : 13'(13'h1FF0 + $urandom_range(0, 15));
                    m_be[i]   = 8'($urandom);
                    m_wd[i]   = {$urandom, $urandom};
                end
            end
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end

        rst_n = 1'b1;
        idle_all();
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
